// File: rtl/sync_event_capture.sv
// sync_event_capture: watches a synchronized bus for enabled rising/falling edges and
// queues {snapshot, edge mask, timestamp} records in a small FIFO for a consumer.
// Optional feature: define SYNC_EVENT_TS_EN to add a free-running timestamp counter;
// without it evt_ts is tied to zero and no timestamp storage exists.
module sync_event_capture #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TS_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            din,
    input  logic                        din_stable,
    input  logic [WIDTH-1:0]            rise_en,
    input  logic [WIDTH-1:0]            fall_en,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [WIDTH-1:0]            evt_data,
    output logic [WIDTH-1:0]            evt_mask,
    output logic [TS_WIDTH-1:0]         evt_ts,
    output logic [$clog2(FIFO_DEPTH):0] evt_count,
    output logic                        overflow,
    input  logic                        overflow_clr
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] det_mask;
    logic             push, pop, full, push_ok, drop;

    logic [WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [WIDTH-1:0] mask_mem [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             overflow_q;

    // State and reference register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
        end
    end

    // Edge detection; the first stable sample only arms the reference
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        det_mask = '0;
        if (din_stable) begin
            ref_d = din;
            case (state_q)
                StInit:  state_d = StRun;
                StRun:   det_mask = (din ^ ref_q) & ((din & rise_en) | (~din & fall_en));
                default: state_d = StInit;
            endcase
        end
    end

    // Queue control; a pop in the same cycle frees the slot a full-queue push needs
    always_comb begin
        push    = |det_mask;
        pop     = evt_valid && evt_ready;
        full    = (count_q == CntW'(FIFO_DEPTH));
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Queue pointers, occupancy and sticky overflow (a drop beats a clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Queue storage; cleared on reset so head outputs read zero while empty after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                mask_mem[i] <= '0;
            end
        end else if (push_ok) begin
            data_mem[wr_ptr_q] <= din;
            mask_mem[wr_ptr_q] <= det_mask;
        end
    end

`ifdef SYNC_EVENT_TS_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] ts_mem [FIFO_DEPTH];

    // Free-running timestamp, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    // Timestamp storage alongside the event records
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ts_mem[i] <= '0;
            end
        end else if (push_ok) begin
            ts_mem[wr_ptr_q] <= ts_q;
        end
    end

    assign evt_ts = ts_mem[rd_ptr_q];
`else
    assign evt_ts = '0;
`endif

    // Head outputs read straight from registered storage
    always_comb begin
        evt_valid = (count_q != '0);
        evt_data  = data_mem[rd_ptr_q];
        evt_mask  = mask_mem[rd_ptr_q];
        evt_count = count_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_sync_event_capture.sv
// Directed testbench for sync_event_capture (default parameters).
module tb_sync_event_capture;

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        din_stable;
    logic [7:0]  rise_en;
    logic [7:0]  fall_en;
    logic        evt_valid;
    logic        evt_ready;
    logic [7:0]  evt_data;
    logic [7:0]  evt_mask;
    logic [15:0] evt_ts;
    logic [2:0]  evt_count;
    logic        overflow;
    logic        overflow_clr;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] cyc;
    logic [15:0] det_ts;

    sync_event_capture dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_stable   (din_stable),
        .rise_en      (rise_en),
        .fall_en      (fall_en),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .evt_mask     (evt_mask),
        .evt_ts       (evt_ts),
        .evt_count    (evt_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release: the expected timestamp when the counter is built in
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 16'd1;
    end

    function automatic logic [15:0] ts_exp(input logic [15:0] c);
`ifdef SYNC_EVENT_TS_EN
        return c;
`else
        return 16'd0 & c;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 8'h00; din_stable = 1'b0; rise_en = 8'h00; fall_en = 8'h00;
        evt_ready = 1'b0; overflow_clr = 1'b0;
        step();
        step();
        n_vec++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: valid=%b count=%0d ovf=%b, want 0/0/0",
                     evt_valid, evt_count, overflow);
        end
        n_vec++;
        if (evt_data !== 8'h00 || evt_mask !== 8'h00 || evt_ts !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_head: data=%h mask=%h ts=%h, want 00/00/0000",
                     evt_data, evt_mask, evt_ts);
        end
        rst = 1'b0;
    endtask

    task automatic test_init();
        din = 8'h05; din_stable = 1'b1; rise_en = 8'hFF; fall_en = 8'h00;
        step();
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL init_no_event: valid=%b, want 0", evt_valid);
        end
        step();
        n_vec++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
            n_err++;
            $display("FAIL init_run_idle: valid=%b count=%0d, want 0/0", evt_valid, evt_count);
        end
    endtask

    task automatic test_rise();
        din = 8'h07;
        det_ts = cyc;
        step();
        n_vec++;
        if (evt_valid !== 1'b1 || evt_data !== 8'h07 || evt_mask !== 8'h02) begin
            n_err++;
            $display("FAIL rise_event: valid=%b data=%h mask=%h, want 1/07/02",
                     evt_valid, evt_data, evt_mask);
        end
        n_vec++;
        if (evt_ts !== ts_exp(det_ts)) begin
            n_err++;
            $display("FAIL rise_ts: ts=%h, want %h", evt_ts, ts_exp(det_ts));
        end
        din = 8'h05;
        step();
        n_vec++;
        if (evt_count !== 3'd1 || evt_data !== 8'h07 || evt_mask !== 8'h02) begin
            n_err++;
            $display("FAIL rise_disabled_fall: count=%0d data=%h mask=%h, want 1/07/02",
                     evt_count, evt_data, evt_mask);
        end
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        n_vec++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
            n_err++;
            $display("FAIL rise_pop: valid=%b count=%0d, want 0/0", evt_valid, evt_count);
        end
    endtask

    task automatic test_stable();
        rst = 1'b1;
        step();
        rst = 1'b0;
        din = 8'h00; din_stable = 1'b1; rise_en = 8'hFF; fall_en = 8'h00;
        step();
        din_stable = 1'b0; din = 8'h01;
        step();
        step();
        n_vec++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
            n_err++;
            $display("FAIL unstable_hold: valid=%b count=%0d, want 0/0", evt_valid, evt_count);
        end
        din_stable = 1'b1;
        step();
        n_vec++;
        if (evt_valid !== 1'b1 || evt_data !== 8'h01 || evt_mask !== 8'h01) begin
            n_err++;
            $display("FAIL stable_event: valid=%b data=%h mask=%h, want 1/01/01",
                     evt_valid, evt_data, evt_mask);
        end
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    task automatic test_fall();
        rise_en = 8'h00; fall_en = 8'h01;
        din = 8'h00;
        step();
        n_vec++;
        if (evt_valid !== 1'b1 || evt_data !== 8'h00 || evt_mask !== 8'h01) begin
            n_err++;
            $display("FAIL fall_event: valid=%b data=%h mask=%h, want 1/00/01",
                     evt_valid, evt_data, evt_mask);
        end
        din = 8'h02;
        step();
        n_vec++;
        if (evt_count !== 3'd1) begin
            n_err++;
            $display("FAIL fall_disabled_rise: count=%0d, want 1", evt_count);
        end
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        n_vec++;
        if (evt_count !== 3'd0) begin
            n_err++;
            $display("FAIL fall_pop: count=%0d, want 0", evt_count);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] seq [5];
        seq[0] = 8'h03; seq[1] = 8'h07; seq[2] = 8'h0F; seq[3] = 8'h1F; seq[4] = 8'h3F;
        rise_en = 8'hFF; fall_en = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            din = seq[i];
            step();
            if (i == 3) begin
                n_vec++;
                if (evt_count !== 3'd4 || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_4: count=%0d ovf=%b, want 4/0", evt_count, overflow);
                end
            end
        end
        n_vec++;
        if (evt_count !== 3'd4 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_drop: count=%0d ovf=%b, want 4/1", evt_count, overflow);
        end
        n_vec++;
        if (evt_data !== 8'h03 || evt_mask !== 8'h01) begin
            n_err++;
            $display("FAIL overflow_head: data=%h mask=%h, want 03/01", evt_data, evt_mask);
        end
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        n_vec++;
        if (overflow !== 1'b0 || evt_count !== 3'd4) begin
            n_err++;
            $display("FAIL overflow_clr: ovf=%b count=%0d, want 0/4", overflow, evt_count);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_d [4];
        logic [7:0] exp_m [4];
        exp_d[0] = 8'h07; exp_m[0] = 8'h04;
        exp_d[1] = 8'h0F; exp_m[1] = 8'h08;
        exp_d[2] = 8'h1F; exp_m[2] = 8'h10;
        exp_d[3] = 8'h7F; exp_m[3] = 8'h40;
        evt_ready = 1'b1;
        din = 8'h7F;
        step();
        n_vec++;
        if (evt_count !== 3'd4 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_push_pop: count=%0d ovf=%b, want 4/0", evt_count, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (evt_valid !== 1'b1 || evt_data !== exp_d[i] || evt_mask !== exp_m[i]) begin
                n_err++;
                $display("FAIL drain_order[%0d]: valid=%b data=%h mask=%h, want 1/%h/%h",
                         i, evt_valid, evt_data, evt_mask, exp_d[i], exp_m[i]);
            end
            step();
        end
        evt_ready = 1'b0;
        n_vec++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
            n_err++;
            $display("FAIL drain_empty: valid=%b count=%0d, want 0/0", evt_valid, evt_count);
        end
    endtask

    task automatic test_set_wins();
        logic [7:0] seq [4];
        seq[0] = 8'h7E; seq[1] = 8'h7C; seq[2] = 8'h78; seq[3] = 8'h70;
        for (int i = 0; i < 4; i++) begin
            din = seq[i];
            step();
        end
        din = 8'h60;
        overflow_clr = 1'b1;
        step();
        n_vec++;
        if (overflow !== 1'b1 || evt_count !== 3'd4) begin
            n_err++;
            $display("FAIL set_wins: ovf=%b count=%0d, want 1/4", overflow, evt_count);
        end
        step();
        overflow_clr = 1'b0;
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL clr_after_set: ovf=%b, want 0", overflow);
        end
    endtask

    task automatic test_midop_reset();
        rst = 1'b1;
        #1;
        n_vec++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0 || evt_data !== 8'h00) begin
            n_err++;
            $display("FAIL async_flush: valid=%b count=%0d data=%h, want 0/0/00",
                     evt_valid, evt_count, evt_data);
        end
        step();
        rst = 1'b0;
        din = 8'h60; din_stable = 1'b1;
        step();
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rearm_init: valid=%b, want 0", evt_valid);
        end
        din = 8'h61;
        det_ts = cyc;
        step();
        n_vec++;
        if (evt_count !== 3'd1 || evt_data !== 8'h61 || evt_mask !== 8'h01) begin
            n_err++;
            $display("FAIL rearm_event: count=%0d data=%h mask=%h, want 1/61/01",
                     evt_count, evt_data, evt_mask);
        end
        n_vec++;
        if (evt_ts !== ts_exp(det_ts)) begin
            n_err++;
            $display("FAIL rearm_ts: ts=%h, want %h", evt_ts, ts_exp(det_ts));
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_rise();
        test_stable();
        test_fall();
        test_overflow();
        test_full_pop();
        test_set_wins();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
